// File: rtl/pipe_adder_pkg.sv
// Shared constants and types for the pipelined ripple-carry adder.
// Optional subtract support is enabled by defining PIPE_ADDER_SUB_EN.
package pipe_adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    // Guarded so an illegal STAGES value still elaborates far enough to report it.
    function automatic int chunkWidth(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    typedef struct packed {
        logic valid;
        logic carry;
        logic sub;
    } stage_ctrl_t;

endpackage

// File: rtl/pipe_adder_stage.sv
// One CHUNK-bit slice of the pipelined adder plus its payload register.
// The subtract flag arrives per operation, so each slice inverts its own chunk of B.
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = chunkWidth(DEFAULT_WIDTH, DEFAULT_STAGES),
    parameter int INDEX = 0,
    parameter bit LAST  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic             carry_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    output logic             valid_o,
    output logic             carry_o,
    output logic             sub_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             ovf_o
);

    localparam int LO = INDEX * CHUNK;

    logic [CHUNK-1:0] bEff;
    logic [CHUNK:0]   chunkSum;
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;

    stage_ctrl_t      ctrl_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             ovf_q;

    always_comb begin
        bEff     = b_i[LO +: CHUNK] ^ {CHUNK{sub_i}};
        chunkSum = {1'b0, a_i[LO +: CHUNK]} + {1'b0, bEff} + {{CHUNK{1'b0}}, carry_i};
        sum_d    = sum_i;
        sum_d[LO +: CHUNK] = chunkSum[CHUNK-1:0];
    end

    // Only the slice holding the MSB can judge signed overflow.
    if (LAST) begin : g_ovf
        assign ovf_d = (a_i[WIDTH-1] == bEff[CHUNK-1]) &&
                       (chunkSum[CHUNK-1] != a_i[WIDTH-1]);
    end else begin : g_no_ovf
        assign ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (en_i) begin
            ctrl_q.valid <= valid_i;
            if (valid_i) begin
                ctrl_q.carry <= chunkSum[CHUNK];
                ctrl_q.sub   <= sub_i;
                a_q          <= a_i;
                b_q          <= b_i;
                sum_q        <= sum_d;
                ovf_q        <= ovf_d;
            end
        end
    end

    assign valid_o = ctrl_q.valid;
    assign carry_o = ctrl_q.carry;
    assign sub_o   = ctrl_q.sub;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign sum_o   = sum_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder with valid/ready on both sides and full backpressure.
// Define PIPE_ADDER_SUB_EN to add the per-operation subtract port.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunkWidth(WIDTH, STAGES);

    if (STAGES < 1) begin : g_bad_stages
        $error("pipe_adder: STAGES must be at least 1");
    end else if ((WIDTH % STAGES) != 0) begin : g_bad_split
        $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end

    logic             adv;
    logic             subIn;
    logic             stValid [STAGES+1];
    logic             stCarry [STAGES+1];
    logic             stSub   [STAGES+1];
    logic [WIDTH-1:0] stA     [STAGES+1];
    logic [WIDTH-1:0] stB     [STAGES+1];
    logic [WIDTH-1:0] stSum   [STAGES+1];
    logic             stOvf   [STAGES];

`ifdef PIPE_ADDER_SUB_EN
    assign subIn = sub;
`else
    assign subIn = 1'b0;
`endif

    // One global enable: a stalled output freezes every slice, bubbles included.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    assign stValid[0] = in_valid;
    assign stCarry[0] = subIn | cin;
    assign stSub[0]   = subIn;
    assign stA[0]     = a;
    assign stB[0]     = b;
    assign stSum[0]   = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .INDEX (k),
            .LAST  (k == STAGES - 1)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (adv),
            .valid_i (stValid[k]),
            .carry_i (stCarry[k]),
            .sub_i   (stSub[k]),
            .a_i     (stA[k]),
            .b_i     (stB[k]),
            .sum_i   (stSum[k]),
            .valid_o (stValid[k+1]),
            .carry_o (stCarry[k+1]),
            .sub_o   (stSub[k+1]),
            .a_o     (stA[k+1]),
            .b_o     (stB[k+1]),
            .sum_o   (stSum[k+1]),
            .ovf_o   (stOvf[k])
        );
    end

    assign out_valid = stValid[STAGES];
    assign sum       = stSum[STAGES];
    assign cout      = stCarry[STAGES];
    assign ovf       = stOvf[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: a negedge monitor models every accepted operation
// and compares results in order; scenario tasks check latency, stalls and reset.
module tb_pipe_adder;

    localparam int WIDTH   = 32;
    localparam int STAGES  = 4;
`ifdef PIPE_ADDER_SUB_EN
    localparam bit SUB_EN  = 1'b1;
`else
    localparam bit SUB_EN  = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int   checks   = 0;
    int   errors   = 0;
    int   outCount = 0;
    int   runLen   = 0;
    int   maxRun   = 0;
    exp_t expQ[$];

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPE_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                   input logic opCin, input logic opSub);
        exp_t             e;
        logic [WIDTH-1:0] bEff;
        logic [WIDTH:0]   full;
        bEff   = opSub ? ~opB : opB;
        full   = {1'b0, opA} + {1'b0, bEff} + {{WIDTH{1'b0}}, (opSub ? 1'b1 : opCin)};
        e.sum  = full[WIDTH-1:0];
        e.cout = full[WIDTH];
        e.ovf  = (opA[WIDTH-1] == bEff[WIDTH-1]) && (full[WIDTH-1] != opA[WIDTH-1]);
        return e;
    endfunction

    // Monitor: inputs and ready only change right after posedge, so negedge sees the coming transfers.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            expQ.delete();
            runLen = 0;
        end else begin
            runLen = out_valid ? runLen + 1 : 0;
            if (runLen > maxRun) maxRun = runLen;
            if (out_valid && out_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_unexpected: got sum=%h cout=%b ovf=%b, expected no output",
                             sum, cout, ovf);
                end else begin
                    e = expQ.pop_front();
                    outCount++;
                    if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
                        errors++;
                        $display("[TB] FAIL scoreboard_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                                 sum, cout, ovf, e.sum, e.cout, e.ovf);
                    end
                end
            end
            if (in_valid && in_ready) expQ.push_back(model(a, b, cin, sub));
        end
    end

    // Presents one operation and returns just after the edge that accepted it, in_valid still high.
    task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                 input logic opCin, input logic opSub);
        int guard = 0;
        a        = opA;
        b        = opB;
        cin      = opCin;
        sub      = opSub & SUB_EN;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        checks++;
        if (guard >= 50) begin
            errors++;
            $display("[TB] FAIL input_accept: waited %0d cycles, expected acceptance within 50", guard);
        end
    endtask

    task automatic waitValid(output int cycles);
        cycles = 1;
        while (!out_valid && cycles < 30) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic waitDrain();
        int guard = 0;
        while ((expQ.size() != 0 || out_valid) && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (guard >= 60) begin
            errors++;
            $display("[TB] FAIL drain: %0d results still pending, expected 0", expQ.size());
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
        if (sum !== '0)         begin errors++; $display("[TB] FAIL reset_sum: got %h, expected 0", sum); end
        if (cout !== 1'b0)      begin errors++; $display("[TB] FAIL reset_cout: got %b, expected 0", cout); end
        if (ovf !== 1'b0)       begin errors++; $display("[TB] FAIL reset_ovf: got %b, expected 0", ovf); end
        if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [3] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [WIDTH-1:0] vb [3] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
        logic [WIDTH-1:0] vs [3] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
        logic             vc [3] = '{1'b1, 1'b0, 1'b1};
        logic             vo [3] = '{1'b0, 1'b1, 1'b1};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(va[i], vb[i], 1'b0, 1'b0);
            in_valid = 1'b0;
            waitValid(lat);
            checks += 4;
            if (lat != STAGES) begin errors++; $display("[TB] FAIL directed_latency[%0d]: got %0d, expected %0d", i, lat, STAGES); end
            if (sum !== vs[i]) begin errors++; $display("[TB] FAIL directed_sum[%0d]: got %h, expected %h", i, sum, vs[i]); end
            if (cout !== vc[i]) begin errors++; $display("[TB] FAIL directed_cout[%0d]: got %b, expected %b", i, cout, vc[i]); end
            if (ovf !== vo[i]) begin errors++; $display("[TB] FAIL directed_ovf[%0d]: got %b, expected %b", i, ovf, vo[i]); end
        end
        waitDrain();
    endtask

    task automatic test_back_to_back();
        int startCount = outCount;
        out_ready = 1'b1;
        maxRun    = 0;
        for (int i = 0; i < 8; i++)
            applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        in_valid = 1'b0;
        waitDrain();
        checks += 2;
        if (outCount - startCount != 8) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d results, expected 8", outCount - startCount);
        end
        if (maxRun != 8) begin
            errors++;
            $display("[TB] FAIL b2b_consecutive: got run of %0d valid cycles, expected 8", maxRun);
        end
    endtask

    task automatic test_backpressure();
        int startCount = outCount;
        logic [WIDTH-1:0] capSum;
        logic             capCout;
        logic             capOvf;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_full: got out_valid=%b, expected 1", out_valid); end
        a         = 32'h1234_5678;
        b         = 32'h0FED_CBA9;
        cin       = 1'b1;
        sub       = 1'b0;
        out_ready = 1'b0;
        capSum    = sum;
        capCout   = cout;
        capOvf    = ovf;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks += 3;
            if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready[%0d]: got %b, expected 0", c, in_ready); end
            if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_out_valid[%0d]: got %b, expected 1", c, out_valid); end
            if ({sum, cout, ovf} !== {capSum, capCout, capOvf}) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d]: got %h/%b/%b, expected %h/%b/%b",
                         c, sum, cout, ovf, capSum, capCout, capOvf);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waitDrain();
        checks++;
        if (outCount - startCount != 5) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d results, expected 5", outCount - startCount);
        end
    endtask

    task automatic test_reset_midstream();
        int lat;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        in_valid = 1'b0;
        @(posedge clk); #3;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_setup: got out_valid=%b, expected 1", out_valid); end
        rst = 1'b1;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b, expected 0", out_valid); end
        if (sum !== '0)         begin errors++; $display("[TB] FAIL midrst_sum: got %h, expected 0", sum); end
        if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL midrst_in_ready: got %b, expected 1", in_ready); end
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stale: got out_valid=%b, expected 0", out_valid); end
        end
        applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        in_valid = 1'b0;
        waitValid(lat);
        checks += 2;
        if (lat != STAGES) begin errors++; $display("[TB] FAIL midrst_latency: got %0d, expected %0d", lat, STAGES); end
        if (sum !== 32'h0000_0100) begin errors++; $display("[TB] FAIL midrst_sum_after: got %h, expected 00000100", sum); end
        waitDrain();
    endtask

`ifdef PIPE_ADDER_SUB_EN
    task automatic test_subtract();
        int lat;
        out_ready = 1'b1;
        applyStimulus(32'd5, 32'd7, 1'b0, 1'b1);
        in_valid = 1'b0;
        waitValid(lat);
        checks += 3;
        if (sum !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL sub_sum_neg: got %h, expected fffffffe", sum); end
        if (cout !== 1'b0) begin errors++; $display("[TB] FAIL sub_cout_neg: got %b, expected 0", cout); end
        if (ovf !== 1'b0)  begin errors++; $display("[TB] FAIL sub_ovf_neg: got %b, expected 0", ovf); end
        waitDrain();
        applyStimulus(32'd7, 32'd5, 1'b0, 1'b1);
        in_valid = 1'b0;
        waitValid(lat);
        checks += 2;
        if (sum !== 32'd2) begin errors++; $display("[TB] FAIL sub_sum_pos: got %h, expected 00000002", sum); end
        if (cout !== 1'b1) begin errors++; $display("[TB] FAIL sub_cout_pos: got %b, expected 1", cout); end
        waitDrain();
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
`ifdef PIPE_ADDER_SUB_EN
        test_subtract();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined ripple-carry adder: the multi-bit, registered successor to the single-bit full adder in the ALU. It splits a WIDTH-bit addition into STAGES equal segments, registers the inter-segment carry, and accepts one operation per cycle. A valid/ready handshake on both sides lets it sit between the ALU operand registers and the result writeback path, with full backpressure.

## Interface
- WIDTH, 32, operand/result width in bits
- STAGES, 4, pipeline depth; CHUNK = WIDTH/STAGES bits per stage; elaboration error if WIDTH % STAGES != 0 or STAGES < 1
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands presented
- in_ready  output  1  pipeline can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- sub  input  1  subtract select (present only with PIPE_ADDER_SUB_EN)
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out of MSB
- ovf  output  1  signed (two's complement) overflow

## Operation
- Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] of A and B plus the registered carry from stage k-1; stage 0 uses cin.
- Operand bits above the current stage travel skewed through the pipe; completed lower sum bits travel forward with them.
- Each stage holds a valid bit; data registers load only when the stage advances.
- Global advance: adv = ~out_valid | out_ready. in_ready = adv (combinational). When adv = 0, every stage holds, including bubbles; bubbles are not collapsed.
- Transfer at input when in_valid & in_ready; at output when out_valid & out_ready.
- cout = carry out of bit WIDTH-1; ovf = (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]), where b_eff is the operand actually added.
- Arithmetic modulo 2^WIDTH; no saturation.
- Reset (async, any time): all valid bits cleared immediately, all data/carry registers zeroed; in-flight operations discarded. Reset values: out_valid 0, sum 0, cout 0, ovf 0, in_ready 1.

## Timing
- Latency: STAGES cycles from input transfer to out_valid, with out_ready held high.
- Throughput: one operation per cycle while out_ready = 1.
- STAGES = 1: single register stage, latency 1.
- Outputs sum/cout/ovf are registered and held stable while out_valid & ~out_ready.
- Simultaneous output accept and input accept in the same cycle is allowed (full pipe keeps streaming).
- Combinational path in_ready <- out_ready/out_valid only; no path from in_valid to in_ready.
- Critical path: one CHUNK-bit ripple plus carry register setup.

## Configuration
- PIPE_ADDER_SUB_EN defined: sub port exists; sub=1 computes a + ~b + 1 (cin ignored, cout = 1 means no borrow); sub travels with its operation through the pipe.
- Not defined: sub port absent; block always computes a + b + cin.

## Structure
- Shared package pipe_adder_pkg: default WIDTH/STAGES constants, CHUNK derivation function, stage payload typedef (valid, carry, partial sum, remaining operands).
- One sub-module natural: pipe_adder_stage, one CHUNK-bit adder plus its payload register and enable; top generates STAGES instances and handshake logic.

## Test plan
- Defaults, a=0xFFFFFFFF, b=0x00000001, cin=0 -> 4 cycles later sum=0x00000000, cout=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1; a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- 8 back-to-back random operations, out_ready=1 -> 8 consecutive out_valid cycles, in-order, matching reference model.
- Pipe full, out_ready low 3 cycles -> in_ready=0, sum/cout/ovf stable, no drop or duplicate; resumes in order on release.
- rst pulsed mid-stream with 3 ops in flight -> out_valid=0 immediately, no stale result after release; next op latency 4.
- PIPE_ADDER_SUB_EN, sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0; a=7, b=5 -> sum=2, cout=1.
